regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file: the next-generation integer register file of the GenshinMIPS core. It provides a configurable number of read ports, two write ports with fixed priority, and write-to-read bypass. An integrated scoreboard tracks registers with outstanding writes so the issue stage can detect RAW hazards without a separate hazard unit. It sits between decode/issue (read, mark-busy) and writeback (write, clear-busy).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- we0 / waddr0 / wdata0  in  1 / ADDR_W / DATA_W  write port 0 (lower priority)
- we1 / waddr1 / wdata1  in  1 / ADDR_W / DATA_W  write port 1 (higher priority)
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, combinational; port i at bits [i*DATA_W +: DATA_W]
- rbusy  out  NUM_RD  per-port: the addressed register has an outstanding write
- issue_valid  in  1  mark issue_waddr busy at this edge
- issue_waddr  in  ADDR_W  destination register of the issuing instruction
- flush  in  1  clear all busy bits (pipeline flush); register contents are untouched
- busy_cnt  out  ADDR_W+1  registered count of currently busy registers

## Operation
- Storage: NUM_REGS x DATA_W flops. Reset clears every register to 0.
- Write: at the edge, if weN and the address is non-zero (or ZERO_REG=0), regs[waddrN] <= wdataN. If both ports target the same address, port 1's data is written.
- Read port i, evaluated in priority order:
  - rst high -> 0
  - re[i] low -> 0
  - address 0 with ZERO_REG -> 0
  - we1 && waddr1 == raddr_i -> wdata1
  - we0 && waddr0 == raddr_i -> wdata0
  - otherwise regs[raddr_i]
- Scoreboard: one busy bit per register.
  - At the edge: each enabled write clears busy[waddrN].
  - issue_valid sets busy[issue_waddr].
  - If a set and a clear hit the same register in one cycle, the set wins, because the issuing instruction is the newer producer.
  - Register 0 is never set when ZERO_REG=1.
- flush: clears all busy bits at the edge and overrides issue_valid in the same cycle. Writes in that cycle still update storage.
- rbusy[i]: busy[raddr_i], masked to 0 in these cases:
  - re[i] is low
  - address 0 with ZERO_REG
  - a write port is writing raddr_i this cycle, since the value is bypassed
- busy_cnt: registered population count of the busy vector after the edge update. It never exceeds NUM_REGS-1 with ZERO_REG=1.

## Timing
- Read latency: 0 cycles (combinational). Write-to-storage latency: 1 edge. Write-to-read is visible in the same cycle via bypass.
- Issue-to-busy: rbusy asserts the cycle after issue_valid. Writeback-to-free: rbusy deasserts in the same cycle via bypass masking, and busy clears at the edge.
- busy_cnt lags the busy vector by zero: it is updated at the same edge from the next-state vector.
- Reset values: all registers 0, all busy 0, busy_cnt 0. rdata and rbusy are 0 while rst is high.
- Reset mid-operation: rst overrides writes, issue and flush in the same cycle.

## Structure
- Shared define file supplies RstEnable, WriteEnable, ReadEnable, ZeroWord. Add RegNum and RegNumLog2 there as the default values for NUM_REGS and ADDR_W.
- Sub-module regfile_scoreboard: busy vector, set/clear/flush priority, popcount for busy_cnt. It is parametrised by ADDR_W and ZERO_REG.
- The read-port mux is a generate loop over NUM_RD inside regfile_mp.

## Test plan
- Reset, then write 0xDEADBEEF to r5 on port 0 and read r5 on both ports in the same cycle -> both return 0xDEADBEEF (bypass). On the next cycle, with we0 low, both still return 0xDEADBEEF.
- we0 and we1 both target r7 with 0x11 and 0x22 -> bypassed read gives 0x22 and the stored value is 0x22. A write of 0xFFFF to r0 -> reads of r0 return 0.
- issue_valid with r3 -> the next cycle shows rbusy=1 for r3 and busy_cnt=1. A writeback to r3 with issue_valid on r3 in the same cycle -> r3 stays busy and busy_cnt stays 1.
- Mark r1, r2 and r4 busy, then assert flush together with issue_valid on r6 -> the next cycle shows busy_cnt=0 and all rbusy=0.
- With re low on port 1 and raddr=r5 holding a non-zero value -> rdata port 1 is 0 and rbusy port 1 is 0.
- Assert rst mid-stream while we0 writes r9 -> the next cycle shows r9 reads 0 and busy_cnt is 0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the GenshinMIPS register file: enable levels,
// the zero word and the default register-file geometry.
package regfile_mp_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        ReadEnable  = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    // Default geometry: 32 architectural registers addressed by 5 bits.
    localparam int          RegNumLog2  = 5;
    localparam int          RegNum      = 1 << RegNumLog2;

endpackage : regfile_mp_pkg

// File: rtl/regfile_mp_scoreboard.sv
// regfile_scoreboard: one busy bit per register, tracking destinations
// that have been issued but not yet written back. Priority at each edge,
// lowest to highest: write-port clears, issue set, flush, reset.
// busy_cnt is the registered population count of the updated vector.
//
// Handshake: there is no back-pressure. issue_valid, we0 and we1 are
// single-cycle qualifiers; each is acted on at the rising edge on which it
// is high and is never held off or retried.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W   = RegNumLog2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_waddr,
    input  logic                       flush,
    output logic [(1 << ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam bit ZR       = (ZERO_REG != 0);

    logic [NUM_REGS-1:0] busy_nxt;
    logic [ADDR_W:0]     cnt_nxt;
    logic                issue_ok;

    // Register 0 is hardwired when ZR, so it can never become busy.
    assign issue_ok = issue_valid && !(ZR && (issue_waddr == '0));

    // Next busy vector: writebacks free, the newer issue re-claims, flush wipes.
    always_comb begin
        busy_nxt = busy;
        if (we0 == WriteEnable) busy_nxt[waddr0] = 1'b0;
        if (we1 == WriteEnable) busy_nxt[waddr1] = 1'b0;
        if (issue_ok)           busy_nxt[issue_waddr] = 1'b1;
        if (flush)              busy_nxt = '0;
    end

    // Population count of the next-state vector so busy_cnt tracks busy exactly.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
        end
    end

    // Busy vector and its count update together; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with two prioritised write
// ports (port 1 wins), combinational read ports with write-to-read bypass,
// and an integrated busy scoreboard for RAW hazard detection at issue.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = RegNumLog2,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_waddr,
    input  logic                       flush,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int                NUM_REGS  = 1 << ADDR_W;
    localparam bit                ZR        = (ZERO_REG != 0);
    localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZeroWord);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr0_ok;
    logic                wr1_ok;
    logic                wr0_en;
    logic                wr1_en;

    assign wr0_en = (we0 == WriteEnable);
    assign wr1_en = (we1 == WriteEnable);

    // Storage writes skip the hardwired zero register.
    assign wr0_ok = wr0_en && !(ZR && (waddr0 == '0));
    assign wr1_ok = wr1_en && !(ZR && (waddr1 == '0));

    // Storage update; port 1 is applied last so it wins on an address clash.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= ZERO_DATA;
            end
        end else begin
            if (wr0_ok) regs[waddr0] <= wdata0;
            if (wr1_ok) regs[waddr1] <= wdata1;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .we0         (we0),
        .waddr0      (waddr0),
        .we1         (we1),
        .waddr1      (waddr1),
        .issue_valid (issue_valid),
        .issue_waddr (issue_waddr),
        .flush       (flush),
        .busy        (busy),
        .busy_cnt    (busy_cnt)
    );

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0;
        logic              hit1;
        logic              zero_hit;
        logic              port_off;
        logic [DATA_W-1:0] rd_val;
        logic              rb_val;

        assign ra       = raddr[gi*ADDR_W +: ADDR_W];
        assign hit0     = wr0_en && (waddr0 == ra);
        assign hit1     = wr1_en && (waddr1 == ra);
        assign zero_hit = ZR && (ra == '0);
        assign port_off = (rst == RstEnable) || (re[gi] != ReadEnable) || zero_hit;

        // Read mux: forced zero, then bypass from port 1, port 0, then storage.
        always_comb begin
            rd_val = ZERO_DATA;
            if (port_off)  rd_val = ZERO_DATA;
            else if (hit1) rd_val = wdata1;
            else if (hit0) rd_val = wdata0;
            else           rd_val = regs[ra];
        end

        // A register being written this cycle is already bypassed, so not busy.
        always_comb begin
            rb_val = 1'b0;
            if (!port_off && !hit0 && !hit1) rb_val = busy[ra];
        end

        assign rdata[gi*DATA_W +: DATA_W] = rd_val;
        assign rbusy[gi]                  = rb_val;
    end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios followed by random traffic,
// all checked against a behavioural register/busy model via an expected queue.
module tb_regfile_mp;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int NUM_REGS = 32;
    localparam int EXP_W    = NUM_RD*DATA_W + NUM_RD + ADDR_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     we0, we1;
    logic [ADDR_W-1:0]        waddr0, waddr1;
    logic [DATA_W-1:0]        wdata0, wdata1;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_waddr;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    regfile_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .issue_valid(issue_valid), .issue_waddr(issue_waddr),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    bit                m_busy [NUM_REGS];
    logic [ADDR_W:0]   m_cnt;

    logic [EXP_W-1:0]  exp_q[$];
    int                tests  = 0;
    int                fails  = 0;
    int                cyc    = 0;

    function automatic logic [ADDR_W-1:0] rd_addr(int p);
        logic [NUM_RD*ADDR_W-1:0] v;
        v = raddr;
        return v[p*ADDR_W +: ADDR_W];
    endfunction

    // What a read port should see, stated from the architectural rules.
    function automatic logic [DATA_W-1:0] model_read(int p);
        logic [ADDR_W-1:0] a;
        a = rd_addr(p);
        if (rst || !re[p] || a == 0) return '0;
        if (we1 && waddr1 == a)      return wdata1;
        if (we0 && waddr0 == a)      return wdata0;
        return m_regs[a];
    endfunction

    function automatic logic model_busy(int p);
        logic [ADDR_W-1:0] a;
        a = rd_addr(p);
        if (rst || !re[p] || a == 0)                      return 1'b0;
        if ((we0 && waddr0 == a) || (we1 && waddr1 == a)) return 1'b0;
        return m_busy[a];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        rst = 0; we0 = 0; we1 = 0; waddr0 = '0; waddr1 = '0;
        wdata0 = '0; wdata1 = '0; re = '0; raddr = '0;
        issue_valid = 0; issue_waddr = '0; flush = 0;
    endtask

    task automatic set_read(int a0, int a1, logic [NUM_RD-1:0] en);
        re    = en;
        raddr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    // Apply current stimulus for one cycle: queue the expected outputs,
    // then advance the model across the coming edge.
    task automatic step(bit check);
        logic [EXP_W-1:0]         e;
        logic [NUM_RD*DATA_W-1:0] ed;
        logic [NUM_RD-1:0]        eb;
        int                       n;
        for (int p = 0; p < NUM_RD; p++) begin
            ed[p*DATA_W +: DATA_W] = model_read(p);
            eb[p]                  = model_busy(p);
        end
        e = {ed, eb, m_cnt};
        if (check) exp_q.push_back(e);
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 0;
            end
        end else begin
            if (we0 && waddr0 != 0) m_regs[waddr0] = wdata0;
            if (we1 && waddr1 != 0) m_regs[waddr1] = wdata1;
            if (we0) m_busy[waddr0] = 0;
            if (we1) m_busy[waddr1] = 0;
            if (issue_valid && issue_waddr != 0) m_busy[issue_waddr] = 1;
            if (flush) for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 0;
        end
        n = 0;
        for (int r = 0; r < NUM_REGS; r++) n += int'(m_busy[r]);
        m_cnt = (ADDR_W+1)'(n);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0]         e;
        logic [NUM_RD*DATA_W-1:0] ed;
        logic [NUM_RD-1:0]        eb;
        logic [ADDR_W:0]          ec;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            {ed, eb, ec} = e;
            for (int p = 0; p < NUM_RD; p++) begin
                tests++;
                if (rdata[p*DATA_W +: DATA_W] !== ed[p*DATA_W +: DATA_W]) begin
                    fails++;
                    $display("FAIL rdata_p%0d cycle %0d: got %h expected %h",
                             p, cyc, rdata[p*DATA_W +: DATA_W], ed[p*DATA_W +: DATA_W]);
                end
            end
            tests++;
            if (rbusy !== eb) begin
                fails++;
                $display("FAIL rbusy cycle %0d: got %b expected %b", cyc, rbusy, eb);
            end
            tests++;
            if (busy_cnt !== ec) begin
                fails++;
                $display("FAIL busy_cnt cycle %0d: got %0d expected %0d", cyc, busy_cnt, ec);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        for (int r = 0; r < NUM_REGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 0;
        end
        m_cnt = '0;
        set_idle();
        rst = 1;
        #1;
        step(0);                       // busy_cnt unknown before first edge
        rst = 1; step(1);

        // Write r5 with same-cycle bypass, then read back from storage.
        set_idle(); we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; set_read(5, 5, 2'b11); step(1);
        set_idle(); set_read(5, 5, 2'b11); step(1);

        // Both ports hit r7: port 1 wins in bypass and storage.
        set_idle(); we0 = 1; waddr0 = 7; wdata0 = 32'h11; we1 = 1; waddr1 = 7; wdata1 = 32'h22;
        set_read(7, 7, 2'b11); step(1);
        set_idle(); set_read(7, 7, 2'b11); step(1);

        // r0 is hardwired to zero.
        set_idle(); we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF; set_read(0, 0, 2'b11); step(1);
        set_idle(); set_read(0, 0, 2'b11); step(1);

        // Issue r3, observe busy, then writeback and reissue r3 together.
        set_idle(); issue_valid = 1; issue_waddr = 3; set_read(3, 3, 2'b11); step(1);
        set_idle(); set_read(3, 3, 2'b11); step(1);
        set_idle(); we0 = 1; waddr0 = 3; wdata0 = 32'h33; issue_valid = 1; issue_waddr = 3;
        set_read(3, 3, 2'b11); step(1);
        set_idle(); set_read(3, 0, 2'b11); step(1);

        // Mark r1, r2, r4 busy, then flush with a competing issue on r6.
        set_idle(); we0 = 1; waddr0 = 3; wdata0 = 32'h34; issue_valid = 1; issue_waddr = 1; step(1);
        set_idle(); issue_valid = 1; issue_waddr = 2; set_read(1, 2, 2'b11); step(1);
        set_idle(); issue_valid = 1; issue_waddr = 4; set_read(1, 2, 2'b11); step(1);
        set_idle(); flush = 1; issue_valid = 1; issue_waddr = 6; set_read(1, 4, 2'b11); step(1);
        set_idle(); set_read(1, 6, 2'b11); step(1);

        // Disabled read port returns zero and not busy.
        set_idle(); issue_valid = 1; issue_waddr = 5; step(1);
        set_idle(); set_read(5, 5, 2'b01); step(1);

        // Reset mid-stream overrides writes and issue.
        set_idle(); we0 = 1; waddr0 = 9; wdata0 = 32'h99; set_read(9, 9, 2'b11); step(1);
        set_idle(); rst = 1; we0 = 1; waddr0 = 9; wdata0 = 32'h1234; issue_valid = 1;
        issue_waddr = 9; set_read(9, 9, 2'b11); step(1);
        set_idle(); set_read(9, 9, 2'b11); step(1);

        // Random traffic on a narrow address window to force collisions.
        for (int k = 0; k < 400; k++) begin
            set_idle();
            rst         = ($urandom_range(0, 60) == 0);
            we0         = $urandom_range(0, 1);
            we1         = ($urandom_range(0, 2) == 0);
            waddr0      = ADDR_W'($urandom_range(0, 7));
            waddr1      = ADDR_W'($urandom_range(0, 7));
            wdata0      = $urandom;
            wdata1      = $urandom;
            issue_valid = $urandom_range(0, 1);
            issue_waddr = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(0, 31))
                                                      : ADDR_W'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 25) == 0);
            set_read($urandom_range(0, 7), $urandom_range(0, 7), NUM_RD'($urandom_range(0, 3)));
            step(1);
        end
        set_idle();

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_mp
